mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Load/store requester that sits between the CPU pipeline and one port of the byte-addressed data BRAM. It accepts one byte, half or word access at a time and turns stores into per-byte BRAM writes. Loads become a single registered BRAM read whose result is sign- or zero-extended. It reports completion or a range error through a one-cycle response pulse.

## Interface
Parameters:
- ADDR_W, default 10: byte address width.
- MEM_BYTES, default 1024: memory size in bytes; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for words and stores.
- req_addr  in  ADDR_W  byte address of the lowest byte; any alignment allowed.
- req_wdata  in  32  store data; byte k = req_wdata[8k+7:8k].
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  qualified by rsp_valid; 1 = request rejected.
- rsp_rdata  out  32  load result; updated only by successful loads.
- mem_wen  out  1  BRAM port write enable.
- mem_b  out  1  BRAM byte-mode flag; held at 1.
- mem_h  out  1  BRAM half flag; held at 0.
- mem_u  out  1  BRAM unsigned flag; held at 0.
- mem_addr  out  ADDR_W  BRAM port address.
- mem_din  out  32  BRAM write data; the write byte is on [7:0], [31:8] = 0.
- mem_dout  in  32  BRAM registered read data {a+3, a+2, a+1, a}; valid one cycle after the address.

## Operation
- The request is transferred on req_valid && req_ready. At transfer, latch addr, size, we, unsigned and wdata. Byte count n = 1, 2 or 4.
- Error check at acceptance: the request is rejected if req_size == 11, or if req_addr + n > MEM_BYTES, computed in ADDR_W+1 bits. A rejected request makes no BRAM access.
- FSM states: IDLE, WRITE, READ, CAPTURE, RESP.
- IDLE -> RESP if the request is rejected, with rsp_err latched to 1.
- IDLE -> WRITE for a legal store. Byte counter k starts at 0.
- IDLE -> READ for a legal load.
- WRITE: drive mem_wen = 1, mem_addr = base + k, mem_din[7:0] = byte k of the latched wdata. Increment k. Go to RESP after k = n-1.
- READ: drive mem_addr = base, mem_wen = 0. Go to CAPTURE.
- CAPTURE: register rsp_rdata from mem_dout:
  - byte: [7:0], extended per the unsigned flag.
  - half: [15:0], extended per the unsigned flag.
  - word: the full 32 bits.
  - Then go to RESP.
- RESP: rsp_valid = 1, rsp_err as latched. Go to IDLE. There is no response backpressure.
- Outside WRITE, mem_wen = 0 and mem_din = 0. mem_addr = 0 in IDLE and RESP.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_err 0, rsp_rdata 0, mem_wen 0, mem_addr 0, mem_din 0, mem_b 1, mem_h 0, mem_u 0.
- Reset mid-operation: abort immediately. Remaining bytes are not written and no response is issued. Bytes already written stay written.
- Stores and errors leave rsp_rdata unchanged.

## Timing
- Take acceptance edge as the end of cycle T.
- Store of n bytes: mem_wen is high in cycles T+1 .. T+n, at ascending addresses. rsp_valid in T+n+1.
- Load: mem_addr is valid in T+1. mem_dout is sampled in T+2. rsp_valid and the new rsp_rdata appear in T+3.
- Error: rsp_valid with rsp_err = 1 in T+1.
- req_ready is low from T+1 until the cycle after the RESP cycle.
- Accepted-to-accepted throughput:
  - word store: 6 cycles
  - load: 4 cycles
  - error: 2 cycles
- Inputs are ignored while not in IDLE; the requester must hold req_valid.

## Test plan
- Word store: 0x11223344 at addr 0x010. Required: mem_wen high T+1..T+4, mem_addr 0x010..0x013, mem_din[7:0] = 44, 33, 22, 11. rsp_valid = 1 with rsp_err = 0 in T+5.
- Byte loads at 0x013 where mem_dout = 0x00000080:
  - signed: rsp_rdata = 0xFFFFFF80 in T+3.
  - unsigned: rsp_rdata = 0x00000080.
  - A half load of mem_dout = 0x0000_8001 gives 0xFFFF8001 signed and 0x00008001 unsigned.
- Range boundary:
  - half load at 0x3FE: accepted, normal 3-cycle load.
  - word load at 0x3FE: rsp_err = 1 in T+1, no mem_wen, mem_addr stays 0.
  - req_size = 11 at 0x000: rsp_err = 1 in T+1.
- Reset mid-store: word store at 0x100, rst asserted in cycle T+2.
  - Only 0x100 is written; no write to 0x101..0x103.
  - No rsp_valid.
  - All outputs are at reset values the cycle after rst; req_ready = 1.
- Back-to-back with req_valid held high: load, then half store, then illegal request.
  - Acceptances at T, T+4, T+8.
  - rsp_valid in T+3, T+7, T+9.
  - rsp_rdata unchanged by the store and error responses.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store requester for one byte-wide-write BRAM port.
// Stores are split into ascending single-byte writes; loads are one registered read, then extended.
module mem_access_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_wen,
  output logic              mem_b,
  output logic              mem_h,
  output logic              mem_u,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_CAPTURE, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic [1:0]        k_q, k_d;

  logic [ADDR_W-1:0] base_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;

  logic [ADDR_W:0]   req_nbytes;
  logic [ADDR_W:0]   req_end;
  logic              req_err;
  logic [1:0]        k_nxt;

  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    case (sz)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = d[7:0];
    h = d[15:0];
    case (sz)
      2'b00:   load_ext = uns ? {24'b0, d[7:0]}  : 32'(b);
      2'b01:   load_ext = uns ? {16'b0, d[15:0]} : 32'(h);
      default: load_ext = d;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] wd, input logic [1:0] k);
    pick_byte = wd[8*k +: 8];
  endfunction

  // The range check runs one bit wider than the address so a+n past the top cannot wrap.
  always_comb begin
    req_nbytes = (ADDR_W+1)'(3'd1 << req_size);
    req_end    = {1'b0, req_addr} + req_nbytes;
    req_err    = (req_size == 2'b11) || (req_end > MEM_LIM);
  end

  assign k_nxt = k_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    mem_wen_d   = 1'b0;
    mem_addr_d  = '0;
    mem_din_d   = '0;
    k_d         = k_q;
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          req_ready_d = 1'b0;
          if (req_err) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we) begin
            state_d    = S_WRITE;
            mem_wen_d  = 1'b1;
            mem_addr_d = req_addr;
            mem_din_d  = req_wdata[7:0];
            k_d        = 2'd0;
          end else begin
            state_d    = S_READ;
            mem_addr_d = req_addr;
          end
        end
      end
      S_WRITE: begin
        if (k_q == last_idx(size_q)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          k_d        = k_nxt;
          mem_wen_d  = 1'b1;
          mem_addr_d = base_q + ADDR_W'(k_nxt);
          mem_din_d  = pick_byte(wdata_q, k_nxt);
        end
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        rsp_rdata_d = load_ext(size_q, uns_q, mem_dout);
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      k_q         <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      k_q         <= k_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_valid && req_ready_q) begin
      base_q  <= req_addr;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata;
    end
  end

  // Reset kills the pending byte write in the same cycle so an aborted store stops at once.
  assign mem_wen   = mem_wen_q & ~rst;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = {24'b0, mem_din_q};
  assign mem_b     = 1'b1;
  assign mem_h     = 1'b0;
  assign mem_u     = 1'b0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural byte-wide BRAM (registered 32-bit read).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_wen, mem_b, mem_h, mem_u;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:1023];
  logic        pk_en = 1'b0;
  logic [9:0]  pk_addr = '0;
  logic [31:0] pk_data = '0;

  mem_access_ctrl #(.ADDR_W(10), .MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_wen(mem_wen), .mem_b(mem_b), .mem_h(mem_h), .mem_u(mem_u), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_din[7:0];
    if (pk_en) begin
      mem[pk_addr]         <= pk_data[7:0];
      mem[pk_addr + 10'd1] <= pk_data[15:8];
      mem[pk_addr + 10'd2] <= pk_data[23:16];
      mem[pk_addr + 10'd3] <= pk_data[31:24];
    end
    mem_dout <= {mem[mem_addr + 10'd3], mem[mem_addr + 10'd2],
                 mem[mem_addr + 10'd1], mem[mem_addr]};
  end

  function automatic logic [31:0] peek(input logic [9:0] a);
    peek = {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
  endfunction

  task automatic poke_w(input logic [9:0] a, input logic [31:0] d);
    pk_addr = a; pk_data = d; pk_en = 1'b1;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  // Drives a request in the current (idle) cycle T and returns at the negedge of T+1.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [9:0] a, input logic [31:0] wd);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b want 0", rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", rsp_rdata); end
    checks++; if ({mem_wen, mem_addr, mem_din} !== 43'h0) begin errors++; $display("FAIL rst_mem_port got wen=%b addr=%h din=%h want 0", mem_wen, mem_addr, mem_din); end
    checks++; if ({mem_b, mem_h, mem_u} !== 3'b100) begin errors++; $display("FAIL rst_flags got %b want 100", {mem_b, mem_h, mem_u}); end
  endtask

  task automatic test_word_store;
    logic [7:0] exp_b [4];
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
    issue(1'b1, 2'b10, 1'b0, 10'h010, 32'h11223344);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL st_ready_low got %b want 0", req_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_wen !== 1'b1 || mem_addr !== 10'h010 + 10'(i) || mem_din !== {24'h0, exp_b[i]} || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL st_byte%0d got wen=%b addr=%h din=%h rv=%b want wen=1 addr=%h din=%h rv=0",
                 i, mem_wen, mem_addr, mem_din, rsp_valid, 10'h010 + 10'(i), {24'h0, exp_b[i]});
      end
      @(negedge clk);
    end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || mem_wen !== 1'b0) begin errors++; $display("FAIL st_resp got rv=%b err=%b wen=%b want 1 0 0", rsp_valid, rsp_err, mem_wen); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL st_rdata_kept got %h want 0", rsp_rdata); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL st_idle got rdy=%b rv=%b want 1 0", req_ready, rsp_valid); end
    checks++; if (peek(10'h010) !== 32'h11223344) begin errors++; $display("FAIL st_mem got %h want 11223344", peek(10'h010)); end
  endtask

  task automatic test_loads;
    logic [9:0]  a   [4] = '{10'h013, 10'h013, 10'h020, 10'h020};
    logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        u   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
    poke_w(10'h013, 32'h00000080);
    poke_w(10'h020, 32'h00008001);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, sz[i], u[i], a[i], 32'hFFFFFFFF);
      checks++; if (mem_addr !== a[i] || mem_wen !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL ld%0d_addr got addr=%h wen=%b rv=%b want %h 0 0", i, mem_addr, mem_wen, rsp_valid, a[i]); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ld%0d_early got rv=%b want 0", i, rsp_valid); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== exp[i]) begin errors++; $display("FAIL ld%0d_data got rv=%b err=%b data=%h want 1 0 %h", i, rsp_valid, rsp_err, rsp_rdata, exp[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_range;
    poke_w(10'h3FC, 32'h9ABC5678);
    issue(1'b0, 2'b01, 1'b0, 10'h3FE, 32'h0);
    checks++; if (mem_addr !== 10'h3FE || rsp_valid !== 1'b0) begin errors++; $display("FAIL rg_half_addr got addr=%h rv=%b want 3fe 0", mem_addr, rsp_valid); end
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hFFFF9ABC) begin errors++; $display("FAIL rg_half_data got rv=%b err=%b data=%h want 1 0 ffff9abc", rsp_valid, rsp_err, rsp_rdata); end
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 10'h3FE, 32'h0);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || mem_wen !== 1'b0 || mem_addr !== 10'h0) begin errors++; $display("FAIL rg_word_err got rv=%b err=%b wen=%b addr=%h want 1 1 0 000", rsp_valid, rsp_err, mem_wen, mem_addr); end
    checks++; if (rsp_rdata !== 32'hFFFF9ABC) begin errors++; $display("FAIL rg_err_rdata got %h want ffff9abc", rsp_rdata); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rg_err_done got rdy=%b rv=%b want 1 0", req_ready, rsp_valid); end
    issue(1'b1, 2'b11, 1'b0, 10'h000, 32'hFFFFFFFF);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || mem_wen !== 1'b0) begin errors++; $display("FAIL rg_size11 got rv=%b err=%b wen=%b want 1 1 0", rsp_valid, rsp_err, mem_wen); end
    @(negedge clk);
    checks++; if (peek(10'h000) === 32'hFFFFFFFF) begin errors++; $display("FAIL rg_size11_nowrite got %h want not ffffffff", peek(10'h000)); end
  endtask

  task automatic test_back_to_back;
    logic rdy_log [12];
    logic rv_log  [12];
    logic err_log [12];
    logic [31:0] rd_log [12];
    poke_w(10'h040, 32'hDEADBEEF);
    poke_w(10'h050, 32'h0);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 10'h040; req_wdata = 32'h0;
    req_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      rdy_log[c] = req_ready; rv_log[c] = rsp_valid; err_log[c] = rsp_err; rd_log[c] = rsp_rdata;
      if (c == 1) begin req_we = 1'b1; req_size = 2'b01; req_addr = 10'h050; req_wdata = 32'h1234A5C3; end
      if (c == 5) begin req_we = 1'b0; req_size = 2'b11; req_addr = 10'h000; end
      if (c == 9) req_valid = 1'b0;
      @(negedge clk);
    end
    for (int c = 0; c < 11; c++) begin
      logic exp_rdy, exp_rv;
      exp_rdy = (c == 0 || c == 4 || c == 8 || c == 10);
      exp_rv  = (c == 3 || c == 7 || c == 9);
      checks++; if (rdy_log[c] !== exp_rdy || rv_log[c] !== exp_rv) begin errors++; $display("FAIL b2b_cyc%0d got rdy=%b rv=%b want %b %b", c, rdy_log[c], rv_log[c], exp_rdy, exp_rv); end
    end
    checks++; if (rd_log[3] !== 32'hDEADBEEF || err_log[3] !== 1'b0) begin errors++; $display("FAIL b2b_load got data=%h err=%b want deadbeef 0", rd_log[3], err_log[3]); end
    checks++; if (rd_log[7] !== 32'hDEADBEEF || err_log[7] !== 1'b0) begin errors++; $display("FAIL b2b_store got data=%h err=%b want deadbeef 0", rd_log[7], err_log[7]); end
    checks++; if (rd_log[9] !== 32'hDEADBEEF || err_log[9] !== 1'b1) begin errors++; $display("FAIL b2b_err got data=%h err=%b want deadbeef 1", rd_log[9], err_log[9]); end
    checks++; if (peek(10'h050) !== 32'h0000A5C3) begin errors++; $display("FAIL b2b_mem got %h want 0000a5c3", peek(10'h050)); end
  endtask

  task automatic test_reset_mid_store;
    logic seen_rv, seen_wen;
    poke_w(10'h100, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 10'h100, 32'hAABBCCDD);
    checks++; if (mem_wen !== 1'b1 || mem_addr !== 10'h100) begin errors++; $display("FAIL rs_first got wen=%b addr=%h want 1 100", mem_wen, mem_addr); end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL rs_abort_wen got %b want 0", mem_wen); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 ||
        mem_wen !== 1'b0 || mem_addr !== 10'h0 || mem_din !== 32'h0 || {mem_b, mem_h, mem_u} !== 3'b100) begin
      errors++;
      $display("FAIL rs_outputs got rdy=%b rv=%b err=%b rd=%h wen=%b addr=%h din=%h bhu=%b want reset values",
               req_ready, rsp_valid, rsp_err, rsp_rdata, mem_wen, mem_addr, mem_din, {mem_b, mem_h, mem_u});
    end
    seen_rv = 1'b0; seen_wen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen_rv  = seen_rv | rsp_valid;
      seen_wen = seen_wen | mem_wen;
    end
    checks++; if (seen_rv !== 1'b0 || seen_wen !== 1'b0) begin errors++; $display("FAIL rs_quiet got rv=%b wen=%b want 0 0", seen_rv, seen_wen); end
    checks++; if (peek(10'h100) !== 32'h000000DD) begin errors++; $display("FAIL rs_mem got %h want 000000dd", peek(10'h100)); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pk_addr = 10'(i & 10'h3FC); pk_data = 32'h0; pk_en = (i % 4 == 0);
      if (i >= 256) break;
    end
    pk_en = 1'b0;
    for (int i = 256; i < 1024; i += 4) poke_w(10'(i), 32'h0);
    @(negedge clk);
    test_reset;
    test_word_store;
    test_loads;
    test_range;
    test_back_to_back;
    test_reset_mid_store;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
